alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Sequential front/back stage wrapped around the combinational 4-bit ALU.
- Buffers incoming ALU commands (A, B, opcode) in a small FIFO.
- Drives the ALU operand/opcode inputs from registers.
- Captures the ALU's 8-bit result and carry into a result register with a valid/ready output handshake.
- Adds zero/divide-by-zero flags and a completed-operation counter.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, minimum 2
CNT_W, 8, width of completed-operation counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO can accept (= !fifo_full)
cmd_a  input  4  operand A
cmd_b  input  4  operand B
cmd_op  input  3  ALU opcode (000 ADD … 111 AVG)
alu_a  output  4  registered operand A to ALU
alu_b  output  4  registered operand B to ALU
alu_op  output  3  registered opcode to ALU
alu_result  input  8  ALU result (combinational from alu_a/alu_b/alu_op)
alu_carry  input  1  ALU carry_out
res_valid  output  1  result register holds an unconsumed result
res_ready  input  1  downstream accepts result
res_data  output  8  captured result
res_carry  output  1  captured carry
res_zero  output  1  res_data == 0
res_err  output  1  divide-by-zero (op 011 with B == 0)
res_op  output  3  opcode that produced the result
busy  output  1  FSM not IDLE or FIFO non-empty
op_count  output  CNT_W  results handed off; wraps

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous assert, synchronous deassert at clk edge. Reset clears FIFO pointers/count, FSM to IDLE, op_count to 0.
- Reset values: all outputs 0 except cmd_ready = 1.
- Reset mid-operation: in-flight and queued commands are discarded; no result is emitted.
- FIFO push: on cmd_valid && cmd_ready.
- FIFO pop: in IDLE when not empty, or in OUT on res_valid && res_ready when not empty.
- Simultaneous push+pop: count unchanged.
- cmd_ready depends only on the registered count, so there is no push at full even when a pop happens in the same cycle.
- FSM IDLE: on fifo non-empty, pop the head into alu_a/alu_b/alu_op; go to EXEC.
- FSM EXEC (exactly 1 cycle, ALU settles combinationally):
  - Capture at the EXEC-ending edge: res_data = alu_result, res_carry = alu_carry, res_op = alu_op, res_zero = (alu_result == 0), res_err = 0.
  - Divide-by-zero (alu_op == 011 && alu_b == 0): instead capture res_data = 0, res_carry = 0, res_zero = 1, res_err = 1.
  - Set res_valid = 1; go to OUT.
- FSM OUT: hold all res_* stable while res_valid && !res_ready. On handshake:
  - Increment op_count; it wraps from 2^CNT_W-1 to 0.
  - Clear res_valid.
  - If fifo non-empty: pop into alu_* and go to EXEC. Otherwise go to IDLE.
- alu_a/alu_b/alu_op hold their last popped values in IDLE and OUT.
- Latency: command accepted at edge k into an empty, IDLE block → popped at edge k+1 → res_valid high after edge k+2.
- Throughput: at most one result per 2 cycles; res_valid is low for exactly one cycle between back-to-back results when res_ready = 1.
- Capacity: DEPTH queued plus 1 in flight (in the ALU registers or the result register).

Test Plan:
- Reset, then ADD A=9 B=8 with res_ready=1 → res_valid 2 cycles after accept; res_data=0x01, res_carry=1, res_zero=0, res_op=000, op_count=1.
- MUL A=0xF B=0xF; NAND A=0xA B=0xC queued back-to-back → res_data=0xE1 then 0x07, in order; one idle res_valid cycle between them; op_count=2.
- DIV A=7 B=0 → res_err=1, res_data=0x00, res_zero=1, res_carry=0. Then DIV A=8 B=2 → res_err=0, res_data=0x04.
- res_ready held 0, cmd_valid held 1 with 7 commands → exactly 5 accepted (1 in result register + 4 in FIFO); cmd_ready=0. res_data stays stable. Release res_ready → all 5 results emerge in order with correct values, then the remaining 2 are accepted.
- Assert rst_n=0 while FSM is in EXEC with 3 queued → all outputs at reset values immediately, busy=0. After release, no stale result appears; a new ADD 1+1 returns 0x02.
- Issue 256 ADD commands with res_ready=1 → op_count wraps to 0 after the 256th handshake.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Command, ALU-drive and result handshake bundle for alu_issue_ctrl.
interface alu_issue_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_op;

    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_carry;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_zero;
    logic       res_err;
    logic [2:0] res_op;

    // The controller accepts commands, drives the ALU and offers results.
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op,
        output cmd_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_carry,
        output res_valid, res_data, res_carry, res_zero, res_err, res_op,
        input  res_ready
    );

    // The surrounding environment: command source, ALU and result sink.
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op,
        input  cmd_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_carry,
        input  res_valid, res_data, res_carry, res_zero, res_err, res_op,
        output res_ready
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller around a combinational 4-bit ALU: command FIFO,
// registered ALU operands and a valid/ready result register.
module alu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.slave  bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] { IDLE, EXEC, OUT } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [10:0]   fifo_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          push;
    logic          pop;
    logic          hand_off;
    logic          div_zero;
    logic [10:0]   head;

    assign empty         = (count == '0);
    assign bus.cmd_ready = (count != FULL);
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign hand_off      = bus.res_valid && bus.res_ready;
    assign head          = fifo_mem[rd_ptr];
    assign div_zero      = (bus.alu_op == 3'b011) && (bus.alu_b == 4'd0);
    assign busy          = (state != IDLE) || !empty;

    // Storage needs no reset; pointers and count alone define valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = OUT;
            OUT: begin
                if (hand_off) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The ALU output has settled by the end of EXEC, so it is captured then;
    // a divide by zero overrides whatever the ALU produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_op    <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_carry <= 1'b0;
            bus.res_zero  <= 1'b0;
            bus.res_err   <= 1'b0;
            bus.res_op    <= '0;
            op_count      <= '0;
        end else begin
            if (pop) begin
                {bus.alu_a, bus.alu_b, bus.alu_op} <= head;
            end
            if (state == EXEC) begin
                bus.res_valid <= 1'b1;
                bus.res_op    <= bus.alu_op;
                bus.res_err   <= div_zero;
                bus.res_data  <= div_zero ? 8'd0 : bus.alu_result;
                bus.res_carry <= div_zero ? 1'b0 : bus.alu_carry;
                bus.res_zero  <= div_zero || (bus.alu_result == 8'd0);
            end else if (hand_off) begin
                bus.res_valid <= 1'b0;
                op_count      <= op_count + CNT_W'(1);
            end
        end
    end
endmodule
